// File: rtl/lcd_frame_driver_if.sv
// Character-writer port of the LCD frame driver: per-cycle character writes in, busy back.
interface lcd_frame_driver_if;
  logic       lcd_we;
  logic       lcd_row;
  logic [3:0] lcd_col;
  logic [7:0] lcd_char;
  logic       lcd_busy;

  modport master (output lcd_we, lcd_row, lcd_col, lcd_char, input lcd_busy);
  modport slave  (input lcd_we, lcd_row, lcd_col, lcd_char, output lcd_busy);
endinterface

// File: rtl/lcd_frame_driver.sv
// HD44780 8-bit frame driver: 2x16 character buffer mirrored to the panel with
// one refresh pass (two cursor commands + 32 data bytes) after each write burst.
module lcd_frame_driver #(
  parameter int unsigned E_CYCLES    = 12,
  parameter int unsigned WAIT_CYCLES = 2000,
  parameter int unsigned CLR_WAIT    = 80000,
  parameter int unsigned INIT_WAIT   = 750000
) (
  input  logic                CLK,
  input  logic                RST,
  lcd_frame_driver_if.slave   wr,
  output logic                LCD_E,
  output logic                LCD_RS,
  output logic                LCD_RW,
  output logic [7:0]          LCD_DB
);

  localparam int unsigned SLOT_MAX = E_CYCLES + ((CLR_WAIT > WAIT_CYCLES) ? CLR_WAIT : WAIT_CYCLES);
  localparam int unsigned CNT_MAX  = (INIT_WAIT > SLOT_MAX) ? INIT_WAIT : SLOT_MAX;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam logic [5:0]  INIT_LAST  = 6'd3;
  localparam logic [5:0]  FRAME_LAST = 6'd33;

  typedef enum logic [1:0] {
    ST_INIT_WAIT,
    ST_INIT_CMD,
    ST_IDLE,
    ST_REFRESH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, slot_last;
  logic [5:0]    idx_q, idx_d;
  logic          dirty_q, dirty_d;
  logic          busy_q, busy_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;
  logic [7:0]    buf_q [32];
  logic [4:0]    wr_addr;
  logic          sending_d;
  logic [8:0]    slot_word;

  assign wr_addr = {wr.lcd_row, wr.lcd_col};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dirty_d   = dirty_q | wr.lcd_we;
    slot_last = CW'(E_CYCLES + (((state_q == ST_INIT_CMD) && (idx_q == 6'd2)) ? CLR_WAIT : WAIT_CYCLES));

    case (state_q)
      ST_INIT_WAIT: begin
        if (cnt_q == CW'(INIT_WAIT - 1)) begin
          state_d = ST_INIT_CMD;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_INIT_CMD, ST_REFRESH: begin
        if (cnt_q == slot_last) begin
          cnt_d = '0;
          if (idx_q == ((state_q == ST_INIT_CMD) ? INIT_LAST : FRAME_LAST)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if (dirty_q && !wr.lcd_we) begin
          state_d = ST_REFRESH;
          cnt_d   = '0;
          idx_d   = '0;
          dirty_d = 1'b0;
        end
      end
      default: state_d = ST_INIT_WAIT;
    endcase

    // Pin values are computed for the cycle described by the next state, so every
    // output (E included) comes straight off a flop.
    sending_d = (state_d == ST_INIT_CMD) || (state_d == ST_REFRESH);
    busy_d    = (state_d != ST_IDLE);
    e_d       = sending_d && (cnt_d != '0) && (cnt_d <= CW'(E_CYCLES));

    if (state_d == ST_INIT_CMD) begin
      case (idx_d)
        6'd0:    slot_word = 9'h038;
        6'd1:    slot_word = 9'h00C;
        6'd2:    slot_word = 9'h001;
        default: slot_word = 9'h006;
      endcase
    end else if (idx_d == 6'd0) begin
      slot_word = 9'h080;
    end else if (idx_d <= 6'd16) begin
      slot_word = {1'b1, buf_q[5'(idx_d - 6'd1)]};
    end else if (idx_d == 6'd17) begin
      slot_word = 9'h0C0;
    end else begin
      slot_word = {1'b1, buf_q[5'(idx_d - 6'd2)]};
    end

    // Bus is latched only at slot start; a same-cycle write lands after the read.
    rs_d = rs_q;
    db_d = db_q;
    if (sending_d && (cnt_d == '0)) begin
      {rs_d, db_d} = slot_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_INIT_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dirty_q <= 1'b0;
      busy_q  <= 1'b1;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        buf_q[i] <= 8'h20;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
      busy_q  <= busy_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      if (wr.lcd_we) begin
        buf_q[wr_addr] <= wr.lcd_char;
      end
    end
  end

  assign wr.lcd_busy = busy_q;
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = 1'b0;
  assign LCD_DB      = db_q;

endmodule
